// File: rtl/map_pkg.sv
// Shared constants, tile-code type and clear-sequencer states
// for the tile-map RAM arbiter.
package map_pkg;

  localparam int MAP_COLS  = 20;
  localparam int MAP_ROWS  = 15;
  localparam int MAP_CELLS = MAP_COLS * MAP_ROWS;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 4;

  typedef logic [DATA_W-1:0] tile_t;

  localparam tile_t TILE_EMPTY = '0;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    CLEAR
  } clr_state_t;

endpackage

// File: rtl/map_clear_counter.sv
// Clear address counter: advances on en, wraps to 0 after LIMIT-1.
// Ports: clk, reset (sync, high), en, count (current address), last (terminal-count pulse).
module map_clear_counter #(
  parameter int W     = 9,
  parameter int LIMIT = 300
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] FINAL = W'(LIMIT - 1);

  assign last = en & (count == FINAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/map_ram_arbiter.sv
// Single-port tile-map RAM arbiter: renderer > map clear > game logic.
// Ports: CLOCK_50/reset; vblank; renderer rd_*; game logic gl_*;
//   clear_start/busy/done; frame_done; RAM side ram_*.
module map_ram_arbiter #(
  parameter int ADDR_W    = map_pkg::ADDR_W,
  parameter int DATA_W    = map_pkg::DATA_W,
  parameter int MAP_CELLS = map_pkg::MAP_CELLS
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              vblank,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic [DATA_W-1:0] gl_wdata,
  output logic              gl_grant,
  output logic              gl_rvalid,
  output logic [DATA_W-1:0] gl_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              frame_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  import map_pkg::*;

  // One spare bit so the bound still compares correctly at 2**ADDR_W.
  localparam logic [ADDR_W:0] CELLS = (ADDR_W+1)'(MAP_CELLS);

  clr_state_t state;
  clr_state_t state_nxt;

  logic              vblank_d;
  logic              rd_hit;
  logic              gl_hit;
  logic              rd_in_map;
  logic              gl_in_map;
  logic              clr_wr;
  logic              clr_last;
  logic [ADDR_W-1:0] clr_addr;

  assign rd_in_map = {1'b0, rd_addr} < CELLS;
  assign gl_in_map = {1'b0, gl_addr} < CELLS;

  // Clear and game logic only ever use vblank cycles the renderer skips.
  assign clr_wr   = (state == CLEAR) & vblank & ~rd_req;
  assign gl_grant = gl_req & vblank & ~rd_req & (state != CLEAR);

  assign clear_busy = (state == PENDING) | (state == CLEAR);

  map_clear_counter #(
    .W     (ADDR_W),
    .LIMIT (MAP_CELLS)
  ) u_clr_cnt (
    .clk   (CLOCK_50),
    .reset (reset),
    .en    (clr_wr),
    .count (clr_addr),
    .last  (clr_last)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clear_start) state_nxt = PENDING;
      PENDING: if (vblank) state_nxt = CLEAR;
      CLEAR:   if (clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The three sources are mutually exclusive by construction.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    unique case (1'b1)
      rd_req: begin
        ram_addr = rd_addr;
      end
      clr_wr: begin
        ram_addr  = clr_addr;
        ram_we    = 1'b1;
        ram_wdata = DATA_W'(TILE_EMPTY);
      end
      gl_grant: begin
        ram_addr  = gl_addr;
        ram_we    = gl_we & gl_in_map;
        ram_wdata = gl_wdata;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      vblank_d   <= 1'b0;
      frame_done <= 1'b0;
      clear_done <= 1'b0;
      rd_valid   <= 1'b0;
      rd_hit     <= 1'b0;
      gl_rvalid  <= 1'b0;
      gl_hit     <= 1'b0;
    end else begin
      state      <= state_nxt;
      vblank_d   <= vblank;
      frame_done <= vblank & ~vblank_d;
      clear_done <= clr_last;
      rd_valid   <= rd_req;
      rd_hit     <= rd_req & rd_in_map;
      gl_rvalid  <= gl_grant & ~gl_we;
      gl_hit     <= gl_grant & ~gl_we & gl_in_map;
    end
  end

  // RAM data arrives the cycle after the address; out-of-map reads give 0.
  assign rd_data  = rd_hit ? ram_rdata : '0;
  assign gl_rdata = gl_hit ? ram_rdata : '0;

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Randomized bench for map_ram_arbiter against a cycle-level map model.
// Ports: none; drives the DUT and a behavioural single-port RAM.
module tb_map_ram_arbiter;

  import map_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       vblank = 1'b0;
  logic       rd_req = 1'b0;
  logic [8:0] rd_addr = '0;
  logic       gl_req = 1'b0;
  logic       gl_we = 1'b0;
  logic [8:0] gl_addr = '0;
  logic [3:0] gl_wdata = '0;
  logic       clear_start = 1'b0;
  logic       rd_valid, gl_grant, gl_rvalid;
  logic       clear_busy, clear_done, frame_done, ram_we;
  logic [3:0] rd_data, gl_rdata, ram_wdata;
  logic [3:0] ram_rdata = '0;
  logic [8:0] ram_addr;
  logic [3:0] mem [512];

  int n_chk = 0;
  int n_fail = 0;

  int  shadow [MAP_CELLS];
  bit  m_pend, m_clr, m_prev_vb;
  int  m_cidx;
  bit  e_rv, e_gv, e_done, e_fd;
  int  e_rd, e_gd;
  int  frames_seen, dones_seen;
  bit  last_grant;
  int  obs_addr;
  bit  obs_we;

  map_ram_arbiter dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .vblank      (vblank),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .gl_req      (gl_req),
    .gl_we       (gl_we),
    .gl_addr     (gl_addr),
    .gl_wdata    (gl_wdata),
    .gl_grant    (gl_grant),
    .gl_rvalid   (gl_rvalid),
    .gl_rdata    (gl_rdata),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .frame_done  (frame_done),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step();
    bit g, cw, p0, c0;
    int ea, ew;
    @(negedge CLOCK_50);
    p0 = m_pend;
    c0 = m_clr;
    g  = gl_req && vblank && !rd_req && !c0;
    cw = c0 && vblank && !rd_req;
    if (rd_req) begin
      ea = rd_addr; ew = 0;
    end else if (cw) begin
      ea = m_cidx; ew = 1;
    end else if (g) begin
      ea = gl_addr; ew = (gl_we && gl_addr < MAP_CELLS) ? 1 : 0;
    end else begin
      ea = 0; ew = 0;
    end
    check("gl_grant", gl_grant, g);
    check("ram_addr", ram_addr, ea);
    check("ram_we", ram_we, ew);
    if (ew != 0) check("ram_wdata", ram_wdata, cw ? 0 : gl_wdata);
    check("clear_busy", clear_busy, p0 || c0);
    obs_addr   = ram_addr;
    obs_we     = ram_we;
    last_grant = g;
    e_rv = rd_req;
    e_rd = (rd_addr < MAP_CELLS) ? shadow[rd_addr] : 0;
    e_gv = g && !gl_we;
    e_gd = (gl_addr < MAP_CELLS) ? shadow[gl_addr] : 0;
    e_fd = vblank && !m_prev_vb;
    m_prev_vb = vblank;
    e_done = 0;
    if (cw) begin
      shadow[m_cidx] = 0;
      m_cidx++;
      if (m_cidx == MAP_CELLS) begin
        m_clr = 0; m_cidx = 0; e_done = 1;
      end
    end else if (g && gl_we && gl_addr < MAP_CELLS) begin
      shadow[gl_addr] = gl_wdata;
    end
    if (p0 && vblank) begin
      m_pend = 0; m_clr = 1;
    end
    if (!p0 && !c0 && clear_start) m_pend = 1;
    @(posedge CLOCK_50);
    #1;
    check("rd_valid", rd_valid, e_rv);
    if (e_rv) check("rd_data", rd_data, e_rd);
    check("gl_rvalid", gl_rvalid, e_gv);
    if (e_gv) check("gl_rdata", gl_rdata, e_gd);
    check("clear_done", clear_done, e_done);
    check("frame_done", frame_done, e_fd);
    if (clear_done) dones_seen++;
    if (frame_done) frames_seen++;
  endtask

  task automatic idle_inputs();
    rd_req = 0; gl_req = 0; gl_we = 0; clear_start = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    vblank = 0;
    reset = 1;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    reset = 0;
    m_pend = 0; m_clr = 0; m_cidx = 0; m_prev_vb = 0;
    check("rst rd_valid", rd_valid, 0);
    check("rst rd_data", rd_data, 0);
    check("rst gl_rvalid", gl_rvalid, 0);
    check("rst gl_rdata", gl_rdata, 0);
    check("rst clear_busy", clear_busy, 0);
    check("rst clear_done", clear_done, 0);
    check("rst frame_done", frame_done, 0);
  endtask

  task automatic gl_op(input bit we, input int a, input int d);
    gl_req = 1; gl_we = we; gl_addr = 9'(a); gl_wdata = 4'(d);
  endtask

  initial begin
    int d0, n_clr, cyc;
    for (int i = 0; i < 512; i++) mem[i] = 4'($urandom_range(1, 15));
    mem[5] = 4'hA;
    mem[310] = 4'hF;
    for (int i = 0; i < MAP_CELLS; i++) shadow[i] = int'(mem[i]);
    frames_seen = 0;
    dones_seen = 0;
    do_reset();

    // Renderer read outside vblank; game logic must wait.
    rd_req = 1; rd_addr = 5; gl_op(0, 8, 0);
    step();
    check("tp1 rd_data", rd_data, 4'hA);
    rd_req = 0;
    step();
    step();
    idle_inputs();

    // Game-logic write then read in vblank.
    vblank = 1;
    step();
    gl_op(1, 17, 3);
    step();
    gl_op(0, 17, 0);
    step();
    check("tp2 gl_rdata", gl_rdata, 3);
    idle_inputs();

    // Collision: renderer wins, game logic granted next cycle.
    rd_req = 1; rd_addr = 2; gl_op(0, 17, 0);
    step();
    check("tp3 lost grant", last_grant, 0);
    rd_req = 0;
    step();
    check("tp3 gl_rvalid", gl_rvalid, 1);
    idle_inputs();

    // Clear: pending outside vblank, then runs with 10 renderer stalls.
    vblank = 0;
    step();
    clear_start = 1;
    step();
    clear_start = 0;
    for (int i = 0; i < 3; i++) step();
    check("tp4 busy", clear_busy, 1);
    vblank = 1;
    d0 = dones_seen;
    n_clr = 0;
    for (int i = 0; i < 700 && dones_seen == d0; i++) begin
      rd_req = (i >= 50 && i < 60);
      rd_addr = 9'($urandom_range(0, 299));
      if (m_clr) n_clr++;
      step();
    end
    rd_req = 0;
    check("tp4 clear_len", n_clr, 310);
    check("tp4 done_cnt", dones_seen - d0, 1);
    vblank = 0;
    for (int a = 0; a < MAP_CELLS; a++) begin
      rd_req = 1; rd_addr = 9'(a);
      step();
      check("tp4 cleared", rd_data, 0);
    end
    rd_req = 0;

    // Out-of-range game-logic accesses.
    vblank = 1;
    step();
    gl_op(1, 300, 7);
    step();
    check("tp5 oor grant", last_grant, 1);
    check("tp5 oor we", obs_we, 0);
    gl_op(0, 310, 0);
    step();
    check("tp5 oor rvalid", gl_rvalid, 1);
    check("tp5 oor rdata", gl_rdata, 0);
    idle_inputs();

    // Two frames give two frame_done pulses.
    vblank = 0;
    for (int i = 0; i < 4; i++) step();
    frames_seen = 0;
    for (int f = 0; f < 2; f++) begin
      vblank = 1;
      for (int i = 0; i < 5; i++) step();
      vblank = 0;
      for (int i = 0; i < 5; i++) step();
    end
    check("tp6 frames", frames_seen, 2);

    // Reset in the middle of a clear.
    clear_start = 1;
    step();
    clear_start = 0;
    vblank = 1;
    for (int i = 0; i < 400 && !(m_clr && m_cidx == 150); i++) step();
    check("tp7 pre-reset addr", obs_addr, 149);
    d0 = dones_seen;
    do_reset();
    vblank = 1;
    for (int i = 0; i < 20; i++) step();
    check("tp7 no done", dones_seen - d0, 0);
    clear_start = 1;
    step();
    clear_start = 0;
    step();
    step();
    check("tp7 restart addr", obs_addr, 0);
    check("tp7 restart we", obs_we, 1);
    for (int i = 0; i < 400 && m_clr; i++) step();
    check("tp7 finished", dones_seen - d0, 1);

    // Randomized traffic over many frames.
    idle_inputs();
    for (cyc = 0; cyc < 3000; cyc++) begin
      vblank = (cyc % 200) >= 140;
      rd_req = vblank ? ($urandom_range(0, 99) < 8) :
                        ($urandom_range(0, 99) < 40);
      rd_addr = 9'($urandom_range(0, 319));
      clear_start = ($urandom_range(0, 399) == 0);
      if (!gl_req && $urandom_range(0, 99) < 30)
        gl_op($urandom_range(0, 1) == 1, $urandom_range(0, 319),
              $urandom_range(0, 15));
      step();
      if (last_grant) gl_req = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/map_ram_arbiter.md
Name: map_ram_arbiter

Overview:
- Arbitrates the single-port tile-map RAM (20x15 tiles of 32x32 px) between the VGA renderer and the robot game logic.
- Sequences a whole-map clear.
- Sits between the VGA timing/pixel pipeline and the game FSM.
- The renderer is never stalled. Game-logic and clear accesses are confined to vertical blanking cycles the renderer leaves free.

Parameters:
- ADDR_W, 9, tile address width
- DATA_W, 4, tile code width
- MAP_CELLS, 300, number of valid tile addresses (0..MAP_CELLS-1)

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- vblank  in  1  high while the VGA timing has pixel_y >= 480
- rd_req  in  1  renderer read request, single cycle
- rd_addr  in  ADDR_W  renderer tile address
- rd_valid  out  1  renderer read data valid
- rd_data  out  DATA_W  renderer read data
- gl_req  in  1  game-logic access request; held until granted
- gl_we  in  1  game-logic write enable (0 = read)
- gl_addr  in  ADDR_W  game-logic address
- gl_wdata  in  DATA_W  game-logic write data
- gl_grant  out  1  combinational: access performed this cycle
- gl_rvalid  out  1  game-logic read data valid
- gl_rdata  out  DATA_W  game-logic read data
- clear_start  in  1  pulse: request clear of the whole map to code 0
- clear_busy  out  1  clear pending or in progress
- clear_done  out  1  one-cycle pulse when the clear completes
- frame_done  out  1  one-cycle pulse on vblank rising edge
- ram_addr  out  ADDR_W  RAM address (combinational mux)
- ram_we  out  1  RAM write enable (combinational)
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, one cycle after the address

Behaviour:
- Reset values: rd_valid, rd_data, gl_rvalid, gl_rdata, clear_busy, clear_done, frame_done all 0; FSM in IDLE; clear counter 0; pending flag 0; vblank_d 0.
- Reset asserted mid-clear aborts the clear. Map contents are undefined afterwards, and no clear_done pulse is issued.
- Priority each cycle: renderer (rd_req) > clear > game logic.
- Renderer access:
  - When rd_req=1: ram_addr=rd_addr, ram_we=0.
  - Next cycle: rd_valid=1, rd_data=ram_rdata.
  - Fixed latency of 1; back-to-back requests are supported.
  - If rd_addr >= MAP_CELLS, rd_data=0.
- FSM states:
  - IDLE -> PENDING on clear_start.
  - PENDING -> CLEAR on the first cycle with vblank=1.
  - CLEAR -> IDLE after address MAP_CELLS-1 is written.
  - clear_start while in PENDING or CLEAR is ignored.
- CLEAR operation:
  - On each cycle with vblank=1 and rd_req=0, write ram_addr=counter, ram_wdata=0, ram_we=1, then increment the counter.
  - Otherwise pause with the counter held.
  - After the last write, pulse clear_done for 1 cycle and reset the counter to 0.
  - clear_busy=1 in PENDING and CLEAR.
- Game-logic grant:
  - gl_grant = gl_req & vblank & ~rd_req & (state != CLEAR).
  - PENDING does not block grants.
  - On a grant, ram_addr=gl_addr, ram_we=gl_we, ram_wdata=gl_wdata.
- Game-logic reads: next cycle gl_rvalid=1, gl_rdata=ram_rdata.
- Game-logic out-of-range addresses (>= MAP_CELLS):
  - Grant is still given.
  - Writes are suppressed (ram_we=0).
  - Reads return gl_rdata=0 with gl_rvalid=1.
- Game-logic writes produce no gl_rvalid.
- frame_done = vblank & ~vblank_d, registered, 1 cycle, once per frame.
- rd_valid and gl_rvalid are never high in the same cycle.
- Idle cycles drive ram_we=0 and ram_addr=0.

Decomposition:
- Shared package map_pkg holds:
  - ADDR_W, DATA_W, MAP_CELLS, MAP_COLS=20, MAP_ROWS=15
  - tile-code typedef, with TILE_EMPTY=0
  - FSM state enum {IDLE, PENDING, CLEAR}
- No sub-module required. The clear address counter may optionally be a small map_clear_counter sub-module (counter with enable and terminal-count pulse).

Test Plan:
- Renderer read, vblank=0: RAM preloaded with addr 5 = 4'hA; rd_req with rd_addr=5 -> next cycle rd_valid=1, rd_data=4'hA; a simultaneous gl_req gets gl_grant=0 throughout.
- Game-logic write then read in vblank: write addr 17 = 4'h3, then read addr 17 -> gl_grant=1 on each request, gl_rvalid=1 one cycle after the read with gl_rdata=4'h3.
- Collision: in vblank, rd_req=1 and gl_req=1 in the same cycle -> gl_grant=0 that cycle, renderer served; gl_grant=1 the next cycle once rd_req=0.
- Clear: clear_start with vblank=0 -> clear_busy=1, no writes. Raise vblank -> 300 writes of 0 over addresses 0..299. Inject 10 rd_req cycles mid-clear -> clear_done pulses exactly after 310 vblank cycles; all addresses then read 0.
- Out-of-range: gl write to addr 300 -> gl_grant=1, ram_we=0. gl read of addr 310 -> gl_rdata=0, gl_rvalid=1.
- Frame and reset: toggle vblank over 2 frames -> exactly 2 frame_done pulses. Assert reset at clear address 150 -> clear_busy=0, no clear_done pulse; a new clear_start restarts from address 0.
